// File: rtl/sp_mem_arbiter.sv
// ============================================================================
// sp_mem_arbiter
//   Round-robin load/store arbiter onto a single request/ready memory port,
//   with read-after-write collision override and a sticky stall watchdog.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sp_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ROW_W  = 2,
    parameter int TO_CYC = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              sLoad,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              sStore,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              sLoad_hit,
    output logic [ROW_W-1:0]  sLoad_row,
    output logic [DATA_W-1:0] load_data,
    output logic              sStore_hit,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err_timeout
);

    localparam int             CNT_W   = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TO_CYC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                rr_q, rr_d;
    logic                op_load_q, op_load_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                grant_store;

    // A same-address collision must let the store land before the load reads.
    assign grant_store = sStore && (!sLoad || rr_q || (load_addr == store_addr));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            row_q       <= '0;
            rr_q        <= 1'b0;
            op_load_q   <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            row_q       <= row_d;
            rr_q        <= rr_d;
            op_load_q   <= op_load_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        row_d       = row_q;
        rr_d        = rr_q;
        op_load_d   = op_load_q;
        cnt_d       = cnt_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sLoad || sStore) begin
                    if (grant_store) begin
                        addr_d    = store_addr;
                        wdata_d   = store_data;
                        op_load_d = 1'b0;
                        rr_d      = 1'b0;
                        state_d   = STORE;
                    end else begin
                        addr_d    = load_addr;
                        op_load_d = 1'b1;
                        rr_d      = 1'b1;
                        state_d   = LOAD;
                    end
                end
            end
            LOAD: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (mem_ready) begin
                    load_data_d = mem_rdata;
                    row_d       = addr_q[ROW_W-1:0];
                    state_d     = RESP;
                end
            end
            STORE: begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                if (mem_ready) state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (((state_q == LOAD) || (state_q == STORE)) && (cnt_d == CNT_MAX)) begin
            err_d = 1'b1;
        end
    end

    assign mem_ren     = (state_q == LOAD);
    assign mem_wen     = (state_q == STORE);
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign sLoad_hit   = (state_q == RESP) && op_load_q;
    assign sStore_hit  = (state_q == RESP) && !op_load_q;
    assign sLoad_row   = row_q;
    assign load_data   = load_data_q;
    assign busy        = (state_q != IDLE);
    assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sp_mem_arbiter.sv
// ============================================================================
// tb_sp_mem_arbiter
//   Directed self-checking bench for sp_mem_arbiter (watchdog limit set to 8).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sp_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;
    localparam int ROW_W  = 2;
    localparam int TO_CYC = 8;

    logic              CLK;
    logic              nRST;
    logic              sLoad;
    logic [ADDR_W-1:0] load_addr;
    logic              sStore;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] store_data;
    logic              sLoad_hit;
    logic [ROW_W-1:0]  sLoad_row;
    logic [DATA_W-1:0] load_data;
    logic              sStore_hit;
    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    sp_mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .ROW_W (ROW_W),
        .TO_CYC(TO_CYC)
    ) u_dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .sLoad      (sLoad),
        .load_addr  (load_addr),
        .sStore     (sStore),
        .store_addr (store_addr),
        .store_data (store_data),
        .sLoad_hit  (sLoad_hit),
        .sLoad_row  (sLoad_row),
        .load_data  (load_data),
        .sStore_hit (sStore_hit),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge: the start of the next cycle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        nRST       = 1'b0;
        sLoad      = 1'b0;
        sStore     = 1'b0;
        load_addr  = '0;
        store_addr = '0;
        store_data = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_ren_wen", {mem_ren, mem_wen}, 0);
        chk("rst_hits", {sLoad_hit, sStore_hit}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ldata", load_data, 0);
        chk("rst_row", sLoad_row, 0);
        chk("rst_err", err_timeout, 0);
        nRST = 1'b1;

        // Single load, zero-wait memory
        sLoad     = 1'b1;
        load_addr = 32'h105;
        mem_ready = 1'b1;
        mem_rdata = 64'hDEAD_BEEF;
        tick();
        chk("sl_ren_c1", mem_ren, 1);
        chk("sl_wen_c1", mem_wen, 0);
        chk("sl_addr_c1", mem_addr, 32'h105);
        chk("sl_hit_c1", sLoad_hit, 0);
        tick();
        chk("sl_hit_c2", sLoad_hit, 1);
        chk("sl_shit_c2", sStore_hit, 0);
        chk("sl_row_c2", sLoad_row, 1);
        chk("sl_data_c2", load_data, 64'hDEAD_BEEF);
        chk("sl_ren_c2", mem_ren, 0);
        sLoad     = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("sl_busy_c3", busy, 0);
        chk("sl_hit_c3", sLoad_hit, 0);
        chk("sl_hold_c3", load_data, 64'hDEAD_BEEF);

        // Round-robin with both requests held, distinct addresses
        do_reset();
        sLoad      = 1'b1;
        load_addr  = 32'h10;
        sStore     = 1'b1;
        store_addr = 32'h23;
        store_data = 64'hAA;
        mem_ready  = 1'b1;
        mem_rdata  = 64'h3C;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d_ren", k), mem_ren, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_wen", k), mem_wen, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 32'h10 : 32'h23);
            tick();
            chk($sformatf("rr%0d_lhit", k), sLoad_hit, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_shit", k), sStore_hit, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("rr%0d_both", k), mem_ren & mem_wen, 0);
            tick();
            chk($sformatf("rr%0d_idle_hit", k), {sLoad_hit, sStore_hit}, 0);
            chk($sformatf("rr%0d_idle_busy", k), busy, 0);
        end
        sLoad  = 1'b0;
        sStore = 1'b0;
        tick();

        // RAW override from rr_ptr=0
        do_reset();
        sLoad      = 1'b1;
        load_addr  = 32'h40;
        sStore     = 1'b1;
        store_addr = 32'h40;
        store_data = 64'h1234;
        mem_ready  = 1'b1;
        mem_rdata  = 64'h5555;
        tick();
        chk("raw_wen", mem_wen, 1);
        chk("raw_ren", mem_ren, 0);
        chk("raw_wdata", mem_wdata, 64'h1234);
        chk("raw_waddr", mem_addr, 32'h40);
        tick();
        chk("raw_shit", sStore_hit, 1);
        chk("raw_lhit0", sLoad_hit, 0);
        sStore = 1'b0;
        tick();
        chk("raw_idle", busy, 0);
        tick();
        chk("raw_ren2", mem_ren, 1);
        chk("raw_raddr", mem_addr, 32'h40);
        tick();
        chk("raw_lhit", sLoad_hit, 1);
        chk("raw_ldata", load_data, 64'h5555);
        chk("raw_row", sLoad_row, 0);
        sLoad     = 1'b0;
        mem_ready = 1'b0;
        tick();

        // Load with 5 wait states
        sLoad     = 1'b1;
        load_addr = 32'h7;
        mem_rdata = 64'hFFFF;
        chk("ws_busy_c0", busy, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("ws_ren_c%0d", c), mem_ren, 1);
            chk($sformatf("ws_addr_c%0d", c), mem_addr, 32'h7);
            chk($sformatf("ws_busy_c%0d", c), busy, 1);
            chk($sformatf("ws_hit_c%0d", c), sLoad_hit, 0);
        end
        tick();
        mem_ready = 1'b1;
        mem_rdata = 64'hCAFE;
        chk("ws_ren_c6", mem_ren, 1);
        tick();
        chk("ws_hit_c7", sLoad_hit, 1);
        chk("ws_busy_c7", busy, 1);
        chk("ws_row_c7", sLoad_row, 3);
        chk("ws_data_c7", load_data, 64'hCAFE);
        chk("ws_err_c7", err_timeout, 0);
        sLoad     = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("ws_busy_c8", busy, 0);

        // Watchdog with TO_CYC=8
        sStore     = 1'b1;
        store_addr = 32'h99;
        store_data = 64'h77;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("wd_err_c%0d", c), err_timeout, 0);
        end
        tick();
        chk("wd_err_c9", err_timeout, 1);
        chk("wd_wen_c9", mem_wen, 1);
        tick();
        tick();
        tick();
        mem_ready = 1'b1;
        chk("wd_err_c12", err_timeout, 1);
        chk("wd_shit_c12", sStore_hit, 0);
        tick();
        chk("wd_shit_c13", sStore_hit, 1);
        chk("wd_err_c13", err_timeout, 1);
        sStore    = 1'b0;
        mem_ready = 1'b0;
        tick();
        chk("wd_err_c14", err_timeout, 1);
        chk("wd_busy_c14", busy, 0);

        // Reset in the middle of a store
        sStore     = 1'b1;
        store_addr = 32'h55;
        store_data = 64'h66;
        tick();
        chk("rm_wen_c1", mem_wen, 1);
        tick();
        nRST = 1'b0;
        #1;
        chk("rm_wen", mem_wen, 0);
        chk("rm_addr", mem_addr, 0);
        chk("rm_wdata", mem_wdata, 0);
        chk("rm_busy", busy, 0);
        chk("rm_err", err_timeout, 0);
        chk("rm_hits", {sLoad_hit, sStore_hit}, 0);
        chk("rm_ldata", load_data, 0);
        tick();
        chk("rm_hit_held", sStore_hit, 0);
        nRST      = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("rm_wen_after", mem_wen, 1);
        chk("rm_addr_after", mem_addr, 32'h55);
        tick();
        chk("rm_shit_after", sStore_hit, 1);
        sStore    = 1'b0;
        mem_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
